// File: rtl/ram_row_writer_pkg.sv
// Shared constants, state encoding and field helper for the feature RAM
// row writer and its read-side consumers.
package ram_row_writer_pkg;

    localparam int FIELD_WIDTH = 16;
    localparam int FIELDS      = 5;
    localparam int DATA_WIDTH  = FIELDS * FIELD_WIDTH;
    localparam int ADDR_WIDTH  = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    // MSB bit index of field k; field 0 sits at the top of the row
    function automatic int field_msb(input int dw, input int fw, input int k);
        return dw - 1 - fw * k;
    endfunction

endpackage

// File: rtl/ram_row_writer_if.sv
// Input value stream plus RAM write port of the feature row writer.
interface ram_row_writer_if #(
    parameter int ADDR_WIDTH  = ram_row_writer_pkg::ADDR_WIDTH,
    parameter int FIELD_WIDTH = ram_row_writer_pkg::FIELD_WIDTH,
    parameter int DATA_WIDTH  = ram_row_writer_pkg::DATA_WIDTH
);

    logic                   in_valid;
    logic                   in_ready;
    logic [FIELD_WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/ram_row_writer_row_packer.sv
// Field counter and packing register: places each value MSB-field-first
// and flags the transfer that completes a row.
module ram_row_writer_row_packer #(
    parameter int FIELD_WIDTH = ram_row_writer_pkg::FIELD_WIDTH,
    parameter int FIELDS      = ram_row_writer_pkg::FIELDS,
    parameter int DATA_WIDTH  = ram_row_writer_pkg::DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [FIELD_WIDTH-1:0] din,
    input  logic                   last,
    output logic [DATA_WIDTH-1:0]  row,
    output logic                   fill_done,
    output logic                   last_seen
);
    import ram_row_writer_pkg::*;

    localparam int CW = $clog2(FIELDS + 1);

    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] row_q;
    logic                  last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            row_q  <= '0;
            last_q <= 1'b0;
        end else if (clear) begin
            cnt_q  <= '0;
            row_q  <= '0;
            last_q <= 1'b0;
        end else if (push) begin
            row_q[field_msb(DATA_WIDTH, FIELD_WIDTH, int'(cnt_q)) -: FIELD_WIDTH] <= din;
            cnt_q  <= cnt_q + 1'b1;
            last_q <= last_q | last;
        end
    end

    assign fill_done = push && ((cnt_q == CW'(FIELDS - 1)) || last);
    assign row       = row_q;
    assign last_seen = last_q;

endmodule

// File: rtl/ram_row_writer.sv
// Loads FIELDS-wide rows from a value stream into the feature RAM,
// one write per row at incrementing addresses, up to DEPTH rows.
module ram_row_writer #(
    parameter int ADDR_WIDTH  = ram_row_writer_pkg::ADDR_WIDTH,
    parameter int FIELD_WIDTH = ram_row_writer_pkg::FIELD_WIDTH,
    parameter int DATA_WIDTH  = ram_row_writer_pkg::DATA_WIDTH,
    parameter int FIELDS      = ram_row_writer_pkg::FIELDS,
    parameter int DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    ram_row_writer_if.slave       bus,
    output logic [ADDR_WIDTH:0]   rows_written,
    output logic                  busy,
    output logic                  done
);
    import ram_row_writer_pkg::*;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_q;
    logic [ADDR_WIDTH:0]   rw_q;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [DATA_WIDTH-1:0] data_hold_q;

    logic                  pk_clear;
    logic                  push;
    logic                  fill_done;
    logic                  last_seen;
    logic                  at_end;
    logic [DATA_WIDTH-1:0] pk_row;

    assign push   = bus.in_valid && (state_q == S_FILL);
    assign at_end = (row_q == ADDR_WIDTH'(DEPTH - 1));

    ram_row_writer_row_packer #(
        .FIELD_WIDTH (FIELD_WIDTH),
        .FIELDS      (FIELDS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .push      (push),
        .din       (bus.in_data),
        .last      (bus.in_last),
        .row       (pk_row),
        .fill_done (fill_done),
        .last_seen (last_seen)
    );

    always_comb begin
        state_d  = state_q;
        pk_clear = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FILL;
                    pk_clear = 1'b1;
                end
            end
            S_FILL: begin
                if (fill_done) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (last_seen || at_end) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_FILL;
                    pk_clear = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            rw_q        <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                row_q <= '0;
                rw_q  <= '0;
            end
            // Hold the bus at the last written row while wr_en is low
            if (state_q == S_WRITE) begin
                rw_q        <= rw_q + 1'b1;
                addr_hold_q <= row_q;
                data_hold_q <= pk_row;
                if (state_d == S_FILL) row_q <= row_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.wr_en     = (state_q == S_WRITE);
    assign bus.wr_addr   = bus.wr_en ? row_q : addr_hold_q;
    assign bus.wr_data   = bus.wr_en ? pk_row : data_hold_q;
    assign rows_written  = rw_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_row_writer.sv
// Directed bench for the feature RAM row writer.
module tb_ram_row_writer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [12:0] rows_written;
    logic        busy;
    logic        done;

    ram_row_writer_if #(
        .ADDR_WIDTH  (12),
        .FIELD_WIDTH (16),
        .DATA_WIDTH  (80)
    ) bus ();

    ram_row_writer #(
        .ADDR_WIDTH  (12),
        .FIELD_WIDTH (16),
        .DATA_WIDTH  (80),
        .FIELDS      (5),
        .DEPTH       (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .rows_written (rows_written),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [11:0] wa[$];
    logic [79:0] wd[$];
    logic [79:0] exp_rows[4];

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            chk("wr_in_ready", 80'(bus.in_ready), 80'd0);
            chk("wr_addr_lt_depth", 80'(bus.wr_addr < 12'(DEPTH)), 80'd1);
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic send(input logic [15:0] d, input logic l, input int gap);
        int n;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 80'(n), 80'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 80'(done_cnt >= target), 80'd1);
        @(negedge clk);
    endtask

    task automatic check_image(input string tag, input int n);
        chk({tag, "_nwr"}, 80'(wa.size()), 80'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 80'(wa[i]), 80'(i));
            chk($sformatf("%s_data%0d", tag, i), wd[i], exp_rows[i]);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        int d0;
        exp_rows[0] = 80'h0001_0002_0003_0004_0005;
        exp_rows[1] = 80'h0006_0007_0008_0009_000a;
        exp_rows[2] = 80'h000b_000c_000d_000e_000f;
        exp_rows[3] = 80'h0010_0011_0012_0013_0014;
        rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 80'(bus.in_ready), 80'd0);
        chk("rst_wr_en", 80'(bus.wr_en), 80'd0);
        chk("rst_wr_addr", 80'(bus.wr_addr), 80'd0);
        chk("rst_wr_data", bus.wr_data, 80'd0);
        chk("rst_rows", 80'(rows_written), 80'd0);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_done", 80'(done), 80'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // full load, valid held high
        clear_log();
        d0 = done_cnt;
        pulse_start();
        chk("fill_busy", 80'(busy), 80'd1);
        for (int i = 1; i <= 20; i++) send(16'(i), i == 20, 0);
        wait_done(d0 + 1);
        check_image("full", 4);
        chk("full_rows", 80'(rows_written), 80'd4);
        chk("full_busy", 80'(busy), 80'd0);
        chk("full_hold_addr", 80'(bus.wr_addr), 80'd3);
        chk("full_hold_data", bus.wr_data, exp_rows[3]);

        // partial row
        clear_log();
        d0 = done_cnt;
        pulse_start();
        chk("part_rows_clr", 80'(rows_written), 80'd0);
        send(16'hAAAA, 1'b0, 0);
        send(16'hBBBB, 1'b0, 0);
        send(16'hCCCC, 1'b1, 0);
        wait_done(d0 + 1);
        chk("part_nwr", 80'(wa.size()), 80'd1);
        if (wa.size() > 0) begin
            chk("part_addr", 80'(wa[0]), 80'd0);
            chk("part_data", wd[0], 80'hAAAA_BBBB_CCCC_0000_0000);
        end
        chk("part_rows", 80'(rows_written), 80'd1);

        // gaps in in_valid
        clear_log();
        d0 = done_cnt;
        pulse_start();
        for (int i = 1; i <= 20; i++)
            send(16'(i), i == 20, int'($urandom_range(0, 2)));
        wait_done(d0 + 1);
        check_image("gap", 4);
        chk("gap_rows", 80'(rows_written), 80'd4);

        // overflow: no in_last, DEPTH ends the load
        clear_log();
        d0 = done_cnt;
        pulse_start();
        for (int i = 1; i <= 20; i++) send(16'(i), 1'b0, 0);
        wait_done(d0 + 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd21;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_ready%0d", i), 80'(bus.in_ready), 80'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_image("ovf", 4);
        chk("ovf_done_once", 80'(done_cnt - d0), 80'd1);
        chk("ovf_rows", 80'(rows_written), 80'd4);

        // reset mid-load after 7 values
        clear_log();
        pulse_start();
        for (int i = 1; i <= 7; i++) send(16'(i), 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 80'(busy), 80'd0);
        chk("mid_rst_ready", 80'(bus.in_ready), 80'd0);
        chk("mid_rst_wr_en", 80'(bus.wr_en), 80'd0);
        chk("mid_rst_addr", 80'(bus.wr_addr), 80'd0);
        chk("mid_rst_data", bus.wr_data, 80'd0);
        chk("mid_rst_rows", 80'(rows_written), 80'd0);
        chk("mid_rst_done", 80'(done), 80'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_nwr", 80'(wa.size()), 80'd1);
        clear_log();
        d0 = done_cnt;
        pulse_start();
        for (int i = 1; i <= 5; i++) send(16'(i), i == 5, 0);
        wait_done(d0 + 1);
        check_image("reload", 1);
        chk("reload_rows", 80'(rows_written), 80'd1);

        // start while busy is ignored
        clear_log();
        d0 = done_cnt;
        pulse_start();
        for (int i = 1; i <= 12; i++) send(16'(i), 1'b0, 0);
        pulse_start();
        chk("sb_busy", 80'(busy), 80'd1);
        chk("sb_rows", 80'(rows_written), 80'd2);
        for (int i = 13; i <= 20; i++) send(16'(i), i == 20, 0);
        wait_done(d0 + 1);
        repeat (4) @(negedge clk);
        check_image("sb", 4);
        chk("sb_done_once", 80'(done_cnt - d0), 80'd1);
        chk("sb_rows_end", 80'(rows_written), 80'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_row_writer.md
Name: ram_row_writer

Overview:
- Write-side companion to the 80-bit feature RAM read port (en/addr/data).
- Accepts a valid/ready stream of 16-bit feature values and packs FIELDS of them per row, MSB-field-first.
- Issues one RAM write per row at incrementing addresses, up to DEPTH rows.
- Sits between the host/load interface and the feature RAM, so the RAM can be filled before the compute engine reads it.

Parameters:
- ADDR_WIDTH, 12, width of the RAM row address.
- FIELD_WIDTH, 16, width of one feature value.
- DATA_WIDTH, 80, RAM row width; must equal FIELDS*FIELD_WIDTH.
- FIELDS, 5, feature values per row (DATA_WIDTH/FIELD_WIDTH).
- DEPTH, 4, number of rows to load; 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load at row 0.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  FIELD_WIDTH  feature value.
- in_last  in  1  marks the final value of the load; qualified by in_valid.
- wr_en  out  1  RAM write strobe, one cycle per row.
- wr_addr  out  ADDR_WIDTH  RAM row address.
- wr_data  out  DATA_WIDTH  packed row.
- rows_written  out  ADDR_WIDTH+1  count of rows committed in the current or last load.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, rows_written=0, busy=0, done=0. Field counter, row counter and packing register are all cleared.
- Reset asserted mid-load aborts the load immediately. Any partially packed row is discarded and no write is issued.

State machine:
- IDLE:
  - in_ready=0.
  - start -> FILL; row counter=0, field counter=0, packing register=0, rows_written=0.
  - start in any other state is ignored.
- FILL:
  - in_ready=1.
  - A transfer occurs when in_valid&&in_ready. Field k (0-based) is stored at bits [DATA_WIDTH-1-FIELD_WIDTH*k -: FIELD_WIDTH], so field 0 occupies the MSBs.
  - The field counter increments on each transfer.
  - When the transfer fills field FIELDS-1, or carries in_last, -> WRITE.
  - On in_last with fewer than FIELDS values, the unfilled fields remain zero.
- WRITE:
  - Lasts exactly one cycle with in_ready=0.
  - wr_en=1, wr_addr=row counter, wr_data=packing register.
  - rows_written increments at the end of this cycle.
  - Exit -> DONE if in_last was seen or the row counter equals DEPTH-1.
  - Otherwise -> FILL, with row counter+1, field counter=0 and packing register=0.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - busy=1 in FILL, WRITE and DONE.

Latency and throughput:
- The row write occurs the cycle after the transfer of its final field.
- Sustained rate is FIELDS transfers per FIELDS+1 cycles.

Boundary conditions:
- DEPTH reached without in_last: load ends and in_ready drops. Surplus input is not accepted (it stays back-pressured) until the next start.
- in_last on the FIELDS-th value: a single write, no padding row.
- in_valid with in_ready=0: data is held by the source; no loss or duplication.
- wr_addr never exceeds DEPTH-1. No wrap-around to 0 within a load.
- wr_en never asserts outside WRITE. wr_addr/wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package holds:
  - FIELD_WIDTH and the FIELDS/DATA_WIDTH relationship constants, shared with the RAM and the read-side slicing logic.
  - the state enumeration (IDLE, FILL, WRITE, DONE).
  - a field-offset helper giving the MSB index of field k.
- One natural sub-module: row_packer, holding the field counter and packing register, with clear, shift-in/place and full/last flags. The FSM and address counter stay in the top level.

Test Plan:
- Full load: start; stream 20 values 0x0001..0x0014 with in_valid held high, in_last on 0x0014 -> 4 writes:
  - addr0=0x00010002000300040005
  - addr1=0x0006000700080009000a
  - addr2=0x000b000c000d000e000f
  - addr3=0x00100011001200130014
  - then done pulse; rows_written=4.
- Partial row: start; stream 0xAAAA,0xBBBB,0xCCCC with in_last on the third -> one write, addr0=0xAAAABBBBCCCC00000000; done; rows_written=1.
- Back-pressure and gaps: random in_valid deasserts, plus check in_ready=0 during each WRITE cycle -> identical RAM image to the full-load case; no duplicated or dropped values.
- Overflow: stream 25 values, no in_last -> exactly 4 writes; done after the 4th; in_ready stays 0 with value 21 held; wr_addr never equals 4.
- Reset mid-load: rst_n low after 7 values accepted -> all outputs at reset values immediately; no write for row 1. A new start then reloads from addr0.
- Start while busy: pulse start during FILL of row 2 -> ignored; addresses continue 2,3; a single done pulse.
